// File: rtl/pio_wmem_rd_arb.sv
// Round-robin read arbiter for the app port of the PIO wide BRAM; tags each read and steers ack/data back to its issuer.
// Grant one cycle after request, response LAT+1 cycles after grant; no buffering, idles after MAX_BURST issues while a PIO read waits.
module pio_wmem_rd_arb #(
   parameter int NREQ        = 4,
   parameter int WIDTH       = 50,
   parameter int DEPTH_NBITS = 10,
   parameter int LAT         = 3,
   parameter int MAX_BURST   = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NREQ-1:0]               req_rd,
   input  logic [NREQ*DEPTH_NBITS-1:0]   req_addr,
   output logic [NREQ-1:0]               req_gnt,
   output logic [NREQ-1:0]               rsp_valid,
   output logic [WIDTH-1:0]              rsp_data,
   input  logic                          pio_rd_pend,
   output logic                          app_mem_rd,
   output logic [DEPTH_NBITS-1:0]        app_mem_raddr,
   input  logic                          app_mem_ack,
   input  logic [WIDTH-1:0]              app_mem_rdata,
   output logic                          err_unexp_ack,
   output logic                          err_lost_ack
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int BCW = $clog2(MAX_BURST + 1);
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   typedef struct packed {
      logic           vld;
      logic [IDW-1:0] id;
   } tag_t;

   logic [NREQ-1:0]        elig;
   logic                   win_vld;
   logic [IDW-1:0]         win_id;
   logic [DEPTH_NBITS-1:0] win_addr;
   logic                   hold;
   logic                   issue;
   logic [IDW-1:0]         rr;
   logic [BCW-1:0]         bc;
   logic [IDW-1:0]         gnt_id;
   tag_t                   tag_q [LAT];
   tag_t                   tail;

   function automatic logic [IDW-1:0] rot(input logic [IDW-1:0] base, input int k);
      return IDW'((int'(base) + k) % NREQ);
   endfunction

   // A requester whose grant is showing this cycle sits out one round.
   assign elig  = req_rd & ~req_gnt;
   assign hold  = (bc == BCW'(MAX_BURST));
   assign issue = win_vld && !hold;
   assign tail  = tag_q[LAT-1];

   always_comb begin
      win_vld  = 1'b0;
      win_id   = '0;
      win_addr = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!win_vld && elig[rot(rr, k)]) begin
            win_vld  = 1'b1;
            win_id   = rot(rr, k);
            win_addr = req_addr[rot(rr, k)*DEPTH_NBITS +: DEPTH_NBITS];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         app_mem_rd    <= 1'b0;
         app_mem_raddr <= '0;
         req_gnt       <= '0;
         gnt_id        <= '0;
         rr            <= '0;
         bc            <= '0;
      end else begin
         app_mem_rd <= issue;
         req_gnt    <= issue ? (ONE << win_id) : '0;
         if (issue) begin
            app_mem_raddr <= win_addr;
            gnt_id        <= win_id;
            rr            <= (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
         end
         bc <= (issue && pio_rd_pend) ? bc + 1'b1 : '0;
      end
   end

   // Tail of this shift register lines up with the memory's ack for the same read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
         rsp_valid     <= '0;
         rsp_data      <= '0;
         err_unexp_ack <= 1'b0;
         err_lost_ack  <= 1'b0;
      end else begin
         tag_q[0] <= {app_mem_rd, gnt_id};
         for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
         rsp_valid <= (app_mem_ack && tail.vld) ? (ONE << tail.id) : '0;
         if (app_mem_ack) rsp_data <= app_mem_rdata;
         if (app_mem_ack && !tail.vld) err_unexp_ack <= 1'b1;
         if (tail.vld && !app_mem_ack) err_lost_ack <= 1'b1;
      end
   end
endmodule

// File: tb/tb_pio_wmem_rd_arb.sv
// Bench for pio_wmem_rd_arb: directed scenarios plus random traffic, checked every cycle against an issue-history model.
module tb_pio_wmem_rd_arb;
   localparam int NREQ = 4;
   localparam int W    = 50;
   localparam int D    = 10;
   localparam int LAT  = 3;
   localparam int MB   = 8;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req_rd;
   logic [NREQ*D-1:0] req_addr;
   logic [NREQ-1:0]   req_gnt;
   logic [NREQ-1:0]   rsp_valid;
   logic [W-1:0]      rsp_data;
   logic              pio_rd_pend;
   logic              app_mem_rd;
   logic [D-1:0]      app_mem_raddr;
   logic              app_mem_ack;
   logic [W-1:0]      app_mem_rdata;
   logic              err_unexp_ack;
   logic              err_lost_ack;

   pio_wmem_rd_arb #(
      .NREQ(NREQ), .WIDTH(W), .DEPTH_NBITS(D), .LAT(LAT), .MAX_BURST(MB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_addr(req_addr),
      .req_gnt(req_gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .pio_rd_pend(pio_rd_pend), .app_mem_rd(app_mem_rd), .app_mem_raddr(app_mem_raddr),
      .app_mem_ack(app_mem_ack), .app_mem_rdata(app_mem_rdata),
      .err_unexp_ack(err_unexp_ack), .err_lost_ack(err_lost_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, want);
      end
   endtask

   function automatic logic [W-1:0] word(input logic [D-1:0] a);
      logic [39:0] h;
      h = ({30'd0, a} * 40'hD1_B54A_32D1) ^ 40'h5A_5A5A_5A5A;
      return {a, h};
   endfunction

   // Reference model: per-edge issue history ring; response of edge n comes from the issue at edge n-LAT-1.
   int              n = 0;
   int              m_rr = 0;
   int              m_bc = 0;
   bit              hv  [16];
   int              hid [16];
   logic [D-1:0]    had [16];
   logic [NREQ-1:0] exp_gnt = '0;
   logic [NREQ-1:0] exp_rsp = '0;
   logic [W-1:0]    exp_data = '0;
   logic [D-1:0]    exp_addr = '0;
   logic            exp_rd = 1'b0;
   logic            exp_eu = 1'b0;
   logic            exp_el = 1'b0;

   always @(posedge clk) begin
      int o, w;
      logic [NREQ-1:0] e;
      if (!rst_n) begin
         m_rr = 0; m_bc = 0;
         exp_gnt = '0; exp_rsp = '0; exp_data = '0; exp_addr = '0;
         exp_rd = 1'b0; exp_eu = 1'b0; exp_el = 1'b0;
         for (int i = 0; i < 16; i++) hv[i] = 1'b0;
      end else begin
         o = (((n - LAT - 1) % 16) + 16) % 16;
         exp_rsp = (app_mem_ack && hv[o]) ? NREQ'(1) << hid[o] : '0;
         if (app_mem_ack) exp_data = hv[o] ? word(had[o]) : app_mem_rdata;
         if (app_mem_ack && !hv[o]) exp_eu = 1'b1;
         if (hv[o] && !app_mem_ack) exp_el = 1'b1;
         e = req_rd & ~exp_gnt;
         w = -1;
         for (int k = 0; k < NREQ; k++)
            if (w < 0 && e[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
         hv[n % 16] = (w >= 0) && (m_bc < MB);
         if (hv[n % 16] && pio_rd_pend) m_bc++; else m_bc = 0;
         exp_rd  = hv[n % 16];
         exp_gnt = exp_rd ? NREQ'(1) << w : '0;
         if (exp_rd) begin
            exp_addr     = req_addr[w*D +: D];
            hid[n % 16]  = w;
            had[n % 16]  = exp_addr;
            m_rr         = (w + 1) % NREQ;
         end
      end
      n++;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_gnt", 64'(req_gnt), 64'(exp_gnt));
         chk("app_mem_rd", 64'(app_mem_rd), 64'(exp_rd));
         chk("app_mem_raddr", 64'(app_mem_raddr), 64'(exp_addr));
         chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
         chk("rsp_data", 64'(rsp_data), 64'(exp_data));
         chk("err_unexp_ack", 64'(err_unexp_ack), 64'(exp_eu));
         chk("err_lost_ack", 64'(err_lost_ack), 64'(exp_el));
      end
   end

   // Memory stand-in: fixed-latency ack pipeline, reset together with the arbiter.
   logic         mp_rd [LAT+1];
   logic [D-1:0] mp_ad [LAT+1];
   bit           force_ack = 1'b0;
   bit           supp_arm = 1'b0;

   task automatic step();
      logic a;
      @(negedge clk);
      for (int s = LAT; s > 0; s--) begin
         mp_rd[s] = mp_rd[s-1];
         mp_ad[s] = mp_ad[s-1];
      end
      mp_rd[0] = app_mem_rd;
      mp_ad[0] = app_mem_raddr;
      if (!rst_n)
         for (int s = 0; s <= LAT; s++) begin mp_rd[s] = 1'b0; mp_ad[s] = '0; end
      a = mp_rd[LAT];
      if (supp_arm && a) begin a = 1'b0; supp_arm = 1'b0; end
      app_mem_ack   = a | force_ack;
      app_mem_rdata = word(mp_ad[LAT]);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_gnt"}, 64'(req_gnt), 64'd0);
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({tag, "_rd"}, 64'(app_mem_rd), 64'd0);
      chk({tag, "_raddr"}, 64'(app_mem_raddr), 64'd0);
      chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
      chk({tag, "_err_unexp"}, 64'(err_unexp_ack), 64'd0);
      chk({tag, "_err_lost"}, 64'(err_lost_ack), 64'd0);
   endtask

   task automatic set_all_addr();
      for (int i = 0; i < NREQ; i++) req_addr[i*D +: D] = D'(10'h40 * i + 3);
   endtask

   initial begin
      logic [NREQ-1:0] one;
      one = 4'b0001;
      rst_n = 1'b0; req_rd = '0; req_addr = '0; pio_rd_pend = 1'b0;
      app_mem_ack = 1'b0; app_mem_rdata = '0;
      for (int s = 0; s <= LAT; s++) begin mp_rd[s] = 1'b0; mp_ad[s] = '0; end
      step();
      chk_en = 1'b1;
      step();
      chk_reset_vals("por");
      rst_n = 1'b1;

      // Single requester, held: grant every 2nd cycle, response 5 cycles after request.
      req_addr[2*D +: D] = 10'h155;
      req_rd = 4'b0100;
      for (int c = 1; c <= 6; c++) begin
         step();
         if (c == 1) begin
            chk("single_gnt", 64'(req_gnt), 64'h4);
            chk("single_raddr", 64'(app_mem_raddr), 64'h155);
         end
         if (c == 2) chk("single_gnt_gap", 64'(req_gnt), 64'h0);
         if (c == 3) chk("single_gnt_again", 64'(req_gnt), 64'h4);
         if (c == 5) begin
            chk("single_rsp_valid", 64'(rsp_valid), 64'h4);
            chk("single_rsp_data", 64'(rsp_data), 64'(word(10'h155)));
         end
      end
      req_rd = '0;
      repeat (8) step();

      // All four requesting continuously from rr=0.
      rst_n = 1'b0; step(); rst_n = 1'b1;
      set_all_addr();
      req_rd = 4'hF;
      for (int c = 0; c < 8; c++) begin
         step();
         chk("rr_seq", 64'(req_gnt), 64'(one << (c % 4)));
      end

      // Burst limiter: 8 issues then one idle while PIO is pending.
      pio_rd_pend = 1'b1;
      for (int j = 0; j < 27; j++) begin
         step();
         chk("burst_rd", 64'(app_mem_rd), 64'((j % 9) != 8));
      end
      pio_rd_pend = 1'b0;
      for (int j = 0; j < 16; j++) begin
         step();
         chk("noburst_rd", 64'(app_mem_rd), 64'd1);
      end
      req_rd = '0;
      repeat (8) step();

      // Unexpected ack, then a suppressed ack.
      force_ack = 1'b1; step(); force_ack = 1'b0; step();
      chk("unexp_set", 64'(err_unexp_ack), 64'd1);
      chk("unexp_no_rsp", 64'(rsp_valid), 64'd0);
      repeat (3) step();
      chk("unexp_sticky", 64'(err_unexp_ack), 64'd1);
      supp_arm = 1'b1;
      req_addr[0 +: D] = 10'h2A;
      req_rd = 4'b0001;
      step();
      req_rd = '0;
      for (int c = 0; c < 8; c++) begin
         step();
         chk("lost_no_rsp", 64'(rsp_valid), 64'd0);
      end
      chk("lost_set", 64'(err_lost_ack), 64'd1);

      // Reset with three reads in flight.
      set_all_addr();
      req_rd = 4'hF;
      repeat (3) step();
      rst_n = 1'b0;
      step();
      chk_reset_vals("midrst");
      rst_n = 1'b1;
      req_rd = 4'b1010;
      for (int c = 1; c <= 4; c++) begin
         step();
         if (c == 1) chk("post_rst_gnt", 64'(req_gnt), 64'h2);
         chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
         chk("post_rst_no_err", 64'({err_unexp_ack, err_lost_ack}), 64'd0);
      end

      // Random traffic obeying the hold-until-grant protocol.
      for (int c = 0; c < 3000; c++) begin
         step();
         for (int i = 0; i < NREQ; i++) begin
            if (req_rd[i]) begin
               if (req_gnt[i] && $urandom_range(1, 0) == 0) req_rd[i] = 1'b0;
            end else if ($urandom_range(2, 0) == 0) begin
               req_rd[i] = 1'b1;
               req_addr[i*D +: D] = D'($urandom);
            end
         end
         if ($urandom_range(19, 0) == 0) pio_rd_pend = ~pio_rd_pend;
      end
      req_rd = '0;
      repeat (8) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pio_wmem_rd_arb.md
# pio_wmem_rd_arb

Round-robin read arbiter that shares the application read port of a PIO-accessible wide BRAM (fixed 3-cycle read-to-ack latency) among NREQ requesters. It issues at most one read per cycle and tags each read in flight, then steers the returned data and ack back to the issuing requester. A burst limiter inserts idle cycles so PIO reads, which lose to application reads inside the memory, are not starved. It sits between the application clients and the memory's app_mem_* port.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 50, memory word width
- DEPTH_NBITS, 10, memory address width
- LAT, 3, cycles from app_mem_rd high to app_mem_ack high
- MAX_BURST, 8, max consecutive issue cycles while pio_rd_pend is high (>=1)
- clk  in  1  the single clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- req_rd  in  NREQ  per-requester read request level; held until the matching req_gnt bit is seen
- req_addr  in  NREQ*DEPTH_NBITS  per-requester address; slice i = [i*DEPTH_NBITS +: DEPTH_NBITS]; stable while req_rd[i] is high
- req_gnt  out  NREQ  one-hot, single-cycle grant pulse
- rsp_valid  out  NREQ  one-hot, single-cycle response strobe
- rsp_data  out  WIDTH  response word, shared by all requesters, qualified by rsp_valid
- pio_rd_pend  in  1  a PIO read of the memory is pending (reg_ms&reg_rd)
- app_mem_rd  out  1  read strobe to memory
- app_mem_raddr  out  DEPTH_NBITS  read address to memory
- app_mem_ack  in  1  read ack from memory
- app_mem_rdata  in  WIDTH  read data from memory
- err_unexp_ack  out  1  sticky: ack received with no read in flight
- err_lost_ack  out  1  sticky: read in flight whose ack did not arrive on time

## Operation
- Eligible set E = req_rd & ~req_gnt. A requester whose grant is currently showing is masked, so a requester gets a grant at most every 2nd cycle. Different requesters can be granted on consecutive cycles.
- Round-robin: a pointer rr holds the highest-priority index. The winner is the first set bit of E scanning rr, rr+1, ... modulo NREQ. After a grant to i, rr <= (i+1) mod NREQ. rr is unchanged when there is no grant. rr resets to 0.
- Issue: if E != 0 and there is no hold, then at the next edge app_mem_rd <= 1, app_mem_raddr <= req_addr slice of the winner, and req_gnt <= onehot(winner). Otherwise app_mem_rd and req_gnt go to 0. app_mem_raddr holds its last value when idle.
- Burst limiter: counter bc, width ceil(log2(MAX_BURST+1)).
  - bc increments on each issue cycle while pio_rd_pend is high.
  - bc clears on any non-issue cycle or when pio_rd_pend is low.
  - When bc == MAX_BURST, hold = 1: the next cycle issues nothing and bc clears.
- Tag pipeline: a LAT-stage shift register of {valid, id}. The stage-0 input is {app_mem_rd, winner id}, and the register advances every cycle. The tail equals the tag of the read issued LAT cycles earlier.
- Response steering, registered:
  - rsp_valid <= (app_mem_ack & tail.valid) ? onehot(tail.id) : 0.
  - rsp_data <= app_mem_rdata whenever app_mem_ack is high.
- Errors:
  - app_mem_ack & ~tail.valid: set err_unexp_ack; no rsp_valid.
  - tail.valid & ~app_mem_ack: set err_lost_ack; that response is dropped.
  - Both flags are sticky until reset.
- Reset, including mid-operation: all tags are invalidated. The memory's ack pipeline shares the same reset, so no stale ack arrives.
- Reset values: req_gnt=0, rsp_valid=0, app_mem_rd=0, app_mem_raddr=0, rsp_data=0, err_unexp_ack=0, err_lost_ack=0, rr=0, bc=0.

## Timing
- A request seen at edge t produces req_gnt and app_mem_rd at t+1 (same cycle T).
- Memory ack arrives at T+LAT; rsp_valid/rsp_data appear at T+LAT+1. Request-to-response is LAT+2 cycles (5 at default).
- Throughput: 1 read/cycle with ≥2 active requesters; 1 read per 2 cycles with a single requester.
- With pio_rd_pend held high and continuous requests, there is exactly one idle cycle after every MAX_BURST issues.
- Order of responses equals order of issue. No reordering or buffering: the requester must accept the rsp_valid cycle.

## Test plan
- Single requester: req_rd[2]=1, addr 0x155 held until grant. Expect req_gnt=4'b0100 and app_mem_raddr=0x155 one cycle after the request, rsp_valid=4'b0100 5 cycles after the request with rsp_data = model word at 0x155, and a grant every 2nd cycle while the request is held.
- All 4 requesting continuously with pio_rd_pend=0: grants are 0,1,2,3,0,... on consecutive cycles, and each response routes to the correct requester with correct data.
- pio_rd_pend=1 with all 4 requesting, MAX_BURST=8: 8 consecutive app_mem_rd cycles then 1 idle cycle, repeating. With pio_rd_pend=0 there are no idle cycles.
- Force app_mem_ack high with no read in flight: err_unexp_ack=1 and stays set, no rsp_valid. Suppress one ack: err_lost_ack=1 and that response is dropped.
- Assert rst_n=0 for 1 cycle with 3 reads in flight: all outputs return to reset values, no rsp_valid after reset, the first grant after reset goes to the lowest requesting index, and there are no error flags.
